// File: rtl/uart_resp_pkg.sv
// Shared command/response codes and FSM state type for the UART command responder.
package uart_resp_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_COUNT = 8'h0A;

  localparam logic [7:0] RESP_ACK  = 8'h06;
  localparam logic [7:0] RESP_NAK  = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_REQ       = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_t;

  // Saturating 8-bit increment for the error counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_cmd_responder.sv
// Single-byte command responder: decodes commands from the UART receive side,
// maintains scratch/count registers, and returns one response byte per command
// through the transmitter's start/ready handshake.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | waiting for a command byte
// ST_WAIT_DATA | WRITE received, waiting for its data byte (with timeout)
// ST_REQ       | tx_start high, waiting for the transmitter to accept
// ST_WAIT_BUSY | transfer accepted, waiting for tx_ready to return high
// ST_WAIT_DONE | one-cycle pass-through back to idle, kept for debug visibility
module uart_cmd_responder
  import uart_resp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk_int,
  input  logic       uart_reset,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_byte,
  output logic       tx_start,
  output logic [7:0] scratch,
  output logic [7:0] cmd_count,
  output logic [7:0] err_count,
  output logic       overrun
);

  // A single-cycle timeout still needs a 1-bit counter to keep widths legal.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_nxt;
  logic [TW-1:0] tmo_cnt;
  logic          ready_seen;
  logic [7:0]    resp_q, resp_nxt;
  logic [7:0]    scratch_q, cmd_count_q, err_count_q;
  logic          overrun_q;

  logic          load_resp;
  logic          inc_cmd;
  logic          inc_err;
  logic          store_scratch;
  logic          tmo_clr;
  logic          set_overrun;

  // State register.
  always_ff @(posedge clk_int or negedge uart_reset) begin
    if (!uart_reset) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  // Next-state decode plus the per-cycle datapath strobes.
  always_comb begin
    state_nxt     = state;
    resp_nxt      = resp_q;
    load_resp     = 1'b0;
    inc_cmd       = 1'b0;
    inc_err       = 1'b0;
    store_scratch = 1'b0;
    tmo_clr       = 1'b0;
    set_overrun   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_valid) begin
          if (rx_byte == CMD_WRITE) begin
            tmo_clr   = 1'b1;
            state_nxt = ST_WAIT_DATA;
          end else begin
            load_resp = 1'b1;
            state_nxt = ST_REQ;
            case (rx_byte)
              CMD_READ: begin
                resp_nxt = scratch_q;
                inc_cmd  = 1'b1;
              end
              CMD_COUNT: begin
                resp_nxt = cmd_count_q + 8'd1;
                inc_cmd  = 1'b1;
              end
              default: begin
                resp_nxt = RESP_NAK;
                inc_err  = 1'b1;
              end
            endcase
          end
        end
      end
      ST_WAIT_DATA: begin
        // Data arriving in the final timeout cycle takes priority over the NAK.
        if (rx_valid) begin
          store_scratch = 1'b1;
          resp_nxt      = RESP_ACK;
          load_resp     = 1'b1;
          inc_cmd       = 1'b1;
          state_nxt     = ST_REQ;
        end else if (tmo_cnt == TMO_LAST) begin
          resp_nxt  = RESP_NAK;
          load_resp = 1'b1;
          inc_err   = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        set_overrun = rx_valid;
        // Accept only a low tx_ready that follows a high one seen in this state.
        if (ready_seen && !tx_ready) state_nxt = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        set_overrun = rx_valid;
        if (tx_ready) state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        set_overrun = rx_valid;
        state_nxt   = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Tracks whether tx_ready has been high during the current request.
  always_ff @(posedge clk_int or negedge uart_reset) begin
    if (!uart_reset)          ready_seen <= 1'b0;
    else if (state != ST_REQ) ready_seen <= 1'b0;
    else if (tx_ready)        ready_seen <= 1'b1;
  end

  // WRITE data timeout counter; restarts on entry to WAIT_DATA.
  always_ff @(posedge clk_int or negedge uart_reset) begin
    if (!uart_reset) begin
      tmo_cnt <= '0;
    end else if (tmo_clr) begin
      tmo_cnt <= '0;
    end else if (state == ST_WAIT_DATA && tmo_cnt != TMO_LAST) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Response byte, scratch register, counters and sticky overrun flag.
  always_ff @(posedge clk_int or negedge uart_reset) begin
    if (!uart_reset) begin
      resp_q      <= 8'h00;
      scratch_q   <= 8'h00;
      cmd_count_q <= 8'h00;
      err_count_q <= 8'h00;
      overrun_q   <= 1'b0;
    end else begin
      if (load_resp)     resp_q      <= resp_nxt;
      if (store_scratch) scratch_q   <= rx_byte;
      if (inc_cmd)       cmd_count_q <= cmd_count_q + 8'd1;
      if (inc_err)       err_count_q <= sat_inc8(err_count_q);
      if (set_overrun)   overrun_q   <= 1'b1;
    end
  end

  assign tx_start  = (state == ST_REQ);
  assign tx_byte   = resp_q;
  assign scratch   = scratch_q;
  assign cmd_count = cmd_count_q;
  assign err_count = err_count_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scoreboard bench: stimulus pushes expected response bytes from a
// behavioural command model; a transmitter model pops and compares on accept.
module tb_uart_cmd_responder;

  localparam int TMO = 40;

  logic       clk_int    = 1'b0;
  logic       uart_reset = 1'b0;
  logic [7:0] rx_byte    = 8'h00;
  logic       rx_valid   = 1'b0;
  logic       tx_ready   = 1'b1;
  logic [7:0] tx_byte;
  logic       tx_start;
  logic [7:0] scratch;
  logic [7:0] cmd_count;
  logic [7:0] err_count;
  logic       overrun;

  uart_cmd_responder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_int   (clk_int),
    .uart_reset(uart_reset),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .tx_ready  (tx_ready),
    .tx_byte   (tx_byte),
    .tx_start  (tx_start),
    .scratch   (scratch),
    .cmd_count (cmd_count),
    .err_count (err_count),
    .overrun   (overrun)
  );

  always #5 clk_int = ~clk_int;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_resp   = 0;
  bit         core_en  = 1'b1;
  logic [7:0] exp_q[$];

  // Reference model state.
  logic [7:0] m_scratch = 8'h00;
  logic [7:0] m_cmd     = 8'h00;
  logic [7:0] m_err     = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_scratch"},   {24'h0, scratch},   {24'h0, m_scratch});
    check({tag, "_cmd_count"}, {24'h0, cmd_count}, {24'h0, m_cmd});
    check({tag, "_err_count"}, {24'h0, err_count}, {24'h0, m_err});
  endtask

  // Transmitter model and response monitor.
  initial begin
    forever begin
      @(negedge clk_int);
      if (core_en && uart_reset && tx_start && tx_ready) begin
        n_resp++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_response: got 0x%0h expected none", tx_byte);
        end else begin
          check("tx_byte", {24'h0, tx_byte}, {24'h0, exp_q.pop_front()});
        end
        @(negedge clk_int);
        tx_ready = 1'b0;
        repeat ($urandom_range(2, 6)) @(negedge clk_int);
        tx_ready = 1'b1;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk_int);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk_int);
    rx_valid = 1'b0;
    rx_byte  = 8'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((exp_q.size() != 0 || !tx_ready || tx_start) && k < 400) begin
      @(negedge clk_int);
      k++;
    end
    if (k >= 400) begin
      n_checks++;
      $display("FAIL %s_wait: got %0d pending expected 0", name, exp_q.size());
    end
    repeat (3) @(negedge clk_int);
  endtask

  // Behavioural command: expected response from the command rules.
  task automatic do_cmd(input logic [7:0] c, input logic [7:0] d);
    if (c == 8'h01) begin
      m_scratch = d;
      m_cmd     = m_cmd + 8'd1;
      exp_q.push_back(8'h06);
      send(c);
      send(d);
    end else if (c == 8'h02) begin
      m_cmd = m_cmd + 8'd1;
      exp_q.push_back(m_scratch);
      send(c);
    end else if (c == 8'h0A) begin
      m_cmd = m_cmd + 8'd1;
      exp_q.push_back(m_cmd);
      send(c);
    end else begin
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
      exp_q.push_back(8'h15);
      send(c);
    end
    wait_idle("cmd");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    logic [7:0] c;
    // Reset state.
    repeat (3) @(negedge clk_int);
    check("rst_tx_start", {31'h0, tx_start}, 32'h0);
    check("rst_tx_byte",  {24'h0, tx_byte},  32'h0);
    check("rst_overrun",  {31'h0, overrun},  32'h0);
    check_regs("rst");
    uart_reset = 1'b1;
    repeat (2) @(negedge clk_int);

    // READ after reset, with one-cycle decode latency.
    m_cmd = m_cmd + 8'd1;
    exp_q.push_back(m_scratch);
    send(8'h02);
    check("start_latency", {31'h0, tx_start}, 32'h1);
    wait_idle("read0");
    check("one_request", n_resp, 1);
    check_regs("read0");

    do_cmd(8'h01, 8'hA5);
    do_cmd(8'h02, 8'h00);
    check_regs("write_read");

    repeat (3) do_cmd(8'h0A, 8'h00);
    check_regs("count");

    // WRITE with no data byte times out into a NAK.
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
    exp_q.push_back(8'h15);
    send(8'h01);
    wait_idle("timeout");
    check_regs("timeout");
    do_cmd(8'h7F, 8'h00);
    check_regs("nak");

    // Data on the last timeout cycle wins over the NAK.
    exp_q.push_back(8'h06);
    send(8'h01);
    repeat (TMO - 1) @(negedge clk_int);
    rx_byte  = 8'h3C;
    rx_valid = 1'b1;
    @(negedge clk_int);
    rx_valid  = 1'b0;
    m_scratch = 8'h3C;
    m_cmd     = m_cmd + 8'd1;
    wait_idle("tmo_edge");
    check_regs("tmo_edge");

    do_cmd(8'h01, 8'h01);
    check_regs("data_is_cmd");

    // Randomised command mix.
    for (int i = 0; i < 60; i++) begin
      r0 = $urandom_range(0, 3);
      case (r0)
        0: do_cmd(8'h01, 8'($urandom));
        1: do_cmd(8'h02, 8'h00);
        2: do_cmd(8'h0A, 8'h00);
        default: begin
          do c = 8'($urandom); while (c == 8'h01 || c == 8'h02 || c == 8'h0A);
          do_cmd(c, 8'h00);
        end
      endcase
      check_regs("rand");
    end
    check("no_overrun_yet", {31'h0, overrun}, 32'h0);

    // Byte arriving while the response is in flight is dropped.
    r0 = n_resp;
    m_cmd = m_cmd + 8'd1;
    exp_q.push_back(m_scratch);
    send(8'h02);
    for (int k = 0; k < 50 && tx_ready; k++) @(negedge clk_int);
    check("busy_seen", {31'h0, tx_ready}, 32'h0);
    send(8'h0A);
    wait_idle("overrun");
    check("overrun_set", {31'h0, overrun}, 32'h1);
    check("overrun_one_resp", n_resp - r0, 1);
    check_regs("overrun");
    do_cmd(8'h02, 8'h00);
    check_regs("after_overrun");

    // Reset while a request is pending.
    core_en = 1'b0;
    send(8'h02);
    @(negedge clk_int);
    check("req_pending", {31'h0, tx_start}, 32'h1);
    uart_reset = 1'b0;
    #1;
    m_scratch = 8'h00;
    m_cmd     = 8'h00;
    m_err     = 8'h00;
    check("rst_mid_tx_start", {31'h0, tx_start}, 32'h0);
    check("rst_mid_overrun",  {31'h0, overrun},  32'h0);
    check("rst_mid_tx_byte",  {24'h0, tx_byte},  32'h0);
    check_regs("rst_mid");
    @(negedge clk_int);
    uart_reset = 1'b1;
    core_en    = 1'b1;
    repeat (2) @(negedge clk_int);
    r0 = n_resp;
    do_cmd(8'h02, 8'h00);
    check("post_rst_one_resp", n_resp - r0, 1);
    check_regs("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
